// File: rtl/cart_bus_master.sv
// GBA slot-2 cartridge bus master: N+S burst reads/writes on the multiplexed AD bus.
// Optional early abort of a burst is compiled in with `define CART_BUS_ABORT_EN.
module cart_bus_master #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 4,
  parameter int WS_W   = 3
) (
  input  logic              phi,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [WS_W-1:0]   cfg_ws_n,
  input  logic [WS_W-1:0]   cfg_ws_s,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              abort,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  input  logic [DATA_W-1:0] ad_in,
  output logic [7:0]        a_hi,
  output logic              ncs,
  output logic              nrd,
  output logic              nwr,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_STROBE,
    S_RECOV,
    S_END
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-2:0]  addr_q, addr_d;
  logic               write_q, write_d;
  logic [LEN_W-1:0]   beats_q, beats_d;
  logic [WS_W-1:0]    ws_n_q, ws_n_d;
  logic [WS_W-1:0]    ws_s_q, ws_s_d;
  logic [WS_W-1:0]    wait_q, wait_d;
  logic [DATA_W-1:0]  beat_data_q, beat_data_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;

  logic abort_hit;
  logic unused_ok;

`ifdef CART_BUS_ABORT_EN
  assign abort_hit = abort;
  assign unused_ok = req_addr[0];
`else
  assign abort_hit = 1'b0;
  assign unused_ok = ^{req_addr[0], abort};
`endif

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q != S_IDLE);

  // Pin strobes are decoded from the state register so reset forces them inactive immediately.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    write_d     = write_q;
    beats_d     = beats_q;
    ws_n_d      = ws_n_q;
    ws_s_d      = ws_s_q;
    wait_d      = wait_q;
    beat_data_d = beat_data_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;

    req_ready = 1'b0;
    wr_ready  = 1'b0;
    ncs       = 1'b1;
    nrd       = 1'b1;
    nwr       = 1'b1;
    ad_oe     = 1'b0;
    ad_out    = '0;
    a_hi      = (state_q == S_IDLE) ? 8'h00 : addr_q[ADDR_W-2:DATA_W];

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr[ADDR_W-1:1];
          write_d = req_write;
          beats_d = req_len;
          ws_n_d  = cfg_ws_n;
          ws_s_d  = cfg_ws_s;
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        ncs    = 1'b0;
        ad_oe  = 1'b1;
        ad_out = addr_q[DATA_W-1:0];
        if (!write_q) begin
          wait_d  = ws_n_q;
          state_d = S_STROBE;
        end else if (wr_valid) begin
          wr_ready    = 1'b1;
          beat_data_d = wr_data;
          wait_d      = ws_n_q;
          state_d     = S_STROBE;
        end else if (abort_hit) begin
          state_d = S_END;
        end
      end

      S_STROBE: begin
        ncs = 1'b0;
        if (write_q) begin
          nwr    = 1'b0;
          ad_oe  = 1'b1;
          ad_out = beat_data_q;
        end else begin
          nrd = 1'b0;
        end
        if (wait_q == '0) begin
          if (!write_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = ad_in;
          end
          if (beats_q == '0) begin
            state_d = S_END;
          end else begin
            beats_d = beats_q - LEN_W'(1);
            state_d = S_RECOV;
          end
        end else begin
          wait_d = wait_q - WS_W'(1);
        end
      end

      // The cartridge auto-increments its address, so RECOV only gaps the strobes.
      S_RECOV: begin
        ncs = 1'b0;
        if (abort_hit) begin
          state_d = S_END;
        end else if (!write_q) begin
          wait_d  = ws_s_q;
          state_d = S_STROBE;
        end else if (wr_valid) begin
          wr_ready    = 1'b1;
          beat_data_d = wr_data;
          wait_d      = ws_s_q;
          state_d     = S_STROBE;
        end
      end

      S_END: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge phi or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      beats_q     <= '0;
      ws_n_q      <= '0;
      ws_s_q      <= '0;
      wait_q      <= '0;
      beat_data_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      beats_q     <= beats_d;
      ws_n_q      <= ws_n_d;
      ws_s_q      <= ws_s_d;
      wait_q      <= wait_d;
      beat_data_q <= beat_data_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_cart_bus_master.sv
// Testbench for cart_bus_master: builds the expected pin timeline of each burst from the
// bus timing rules and compares the DUT against it cycle by cycle.
module tb_cart_bus_master;

`ifdef CART_BUS_ABORT_EN
  localparam bit ABORT_ON = 1'b1;
`else
  localparam bit ABORT_ON = 1'b0;
`endif

  logic        phi = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [24:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [3:0]  req_len = '0;
  logic [2:0]  cfg_ws_n = '0;
  logic [2:0]  cfg_ws_s = '0;
  logic [15:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        abort = 1'b0;
  logic [15:0] ad_out;
  logic        ad_oe;
  logic [15:0] ad_in = '0;
  logic [7:0]  a_hi;
  logic        ncs, nrd, nwr, busy;

  cart_bus_master dut (
    .phi(phi), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_len(req_len),
    .cfg_ws_n(cfg_ws_n), .cfg_ws_s(cfg_ws_s),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .abort(abort),
    .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in), .a_hi(a_hi),
    .ncs(ncs), .nrd(nrd), .nwr(nwr), .busy(busy)
  );

  always #5 phi = ~phi;

  // One entry per bus cycle: what the bench drives and what the pins must show.
  typedef struct {
    logic        req_valid, wr_valid, abort_in;
    logic [15:0] wr_data, ad_in;
    logic [24:0] addr;
    logic        write;
    logic [3:0]  len;
    logic [2:0]  wsn, wss;
    logic        ncs, nrd, nwr, busy, req_ready, rd_valid, wr_ready, ad_oe;
    bit          oe_care, out_care, hi_care;
    logic [15:0] ad_out, rd_data;
    logic [7:0]  a_hi;
  } cyc_t;

  cyc_t        plan[$];
  logic [15:0] beat_wdata[16];
  int          beat_stall[16];
  logic [15:0] beat_rdv[16];
  bit          pend;
  logic [15:0] pend_data;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [15:0] rnd16();
    return 16'($urandom);
  endfunction

  task automatic randomize_beats();
    for (int i = 0; i < 16; i++) begin
      beat_wdata[i] = rnd16();
      beat_stall[i] = $urandom_range(0, 2);
      beat_rdv[i]   = rnd16();
    end
  endtask

  function automatic cyc_t base_cycle(input logic [24:0] addr, input logic wr, input int len,
                                      input int wsn, input int wss, input bit hold);
    cyc_t c;
    c.req_valid = hold ? 1'b1 : 1'($urandom);
    c.wr_valid  = 1'($urandom);
    c.abort_in  = 1'b0;
    c.wr_data   = rnd16();
    c.ad_in     = rnd16();
    c.addr      = addr;
    c.write     = wr;
    c.len       = 4'(len);
    c.wsn       = 3'(wsn);
    c.wss       = 3'(wss);
    c.ncs = 1'b1; c.nrd = 1'b1; c.nwr = 1'b1; c.busy = 1'b1;
    c.req_ready = 1'b0; c.rd_valid = 1'b0; c.wr_ready = 1'b0; c.ad_oe = 1'b0;
    c.oe_care = 1'b1; c.out_care = 1'b0; c.hi_care = 1'b1;
    c.ad_out = '0; c.rd_data = '0;
    c.a_hi = addr[24:17];
    return c;
  endfunction

  // A read beat shows up on rd_data in the cycle after its last strobe cycle.
  task automatic push_cycle(input cyc_t c_in);
    cyc_t c;
    c = c_in;
    c.rd_valid = pend;
    c.rd_data  = pend ? pend_data : 16'h0000;
    pend = 1'b0;
    plan.push_back(c);
  endtask

  task automatic add_idle();
    cyc_t c;
    c = base_cycle('0, 1'b0, 0, 0, 0, 1'b0);
    c.req_valid = 1'b0;
    c.busy = 1'b0; c.req_ready = 1'b1; c.hi_care = 1'b0;
    push_cycle(c);
  endtask

  task automatic add_burst(input logic [24:0] addr, input logic wr, input int len,
                           input int wsn, input int wss, input bit hold, input int abort_beat);
    cyc_t c;
    int   ws, nst;
    c = base_cycle(addr, wr, len, wsn, wss, hold);
    c.req_valid = 1'b1;
    c.busy = 1'b0; c.req_ready = 1'b1; c.hi_care = 1'b0;
    push_cycle(c);
    for (int b = 0; b <= len; b++) begin
      ws  = (b == 0) ? wsn : wss;
      nst = wr ? beat_stall[b] : 0;
      for (int s = 0; s <= nst; s++) begin
        c = base_cycle(addr, wr, len, wsn, wss, hold);
        c.ncs = 1'b0;
        if (b == 0) begin
          c.ad_oe = 1'b1; c.out_care = 1'b1; c.ad_out = addr[16:1];
        end else begin
          c.oe_care = 1'b0;
        end
        if (wr) begin
          c.wr_valid = (s == nst);
          c.wr_ready = (s == nst);
          if (s == nst) c.wr_data = beat_wdata[b];
        end
        if (b == abort_beat) c.abort_in = 1'b1;
        push_cycle(c);
      end
      if (b == abort_beat && ABORT_ON) break;
      for (int k = 0; k <= ws; k++) begin
        c = base_cycle(addr, wr, len, wsn, wss, hold);
        c.ncs = 1'b0;
        if (wr) begin
          c.nwr = 1'b0; c.ad_oe = 1'b1; c.out_care = 1'b1; c.ad_out = beat_wdata[b];
        end else begin
          c.nrd = 1'b0;
          if (k == ws) c.ad_in = beat_rdv[b];
        end
        push_cycle(c);
      end
      if (!wr) begin
        pend = 1'b1;
        pend_data = beat_rdv[b];
      end
    end
    c = base_cycle(addr, wr, len, wsn, wss, hold);
    push_cycle(c);
  endtask

  task automatic check_bit(input string tag, input int idx, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s @entry %0d: observed %b expected %b", tag, idx, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input int idx, input logic [15:0] obs,
                           input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s @entry %0d: observed %h expected %h", tag, idx, obs, exp);
    end
  endtask

  task automatic checkOutput(input cyc_t c, input int idx);
    check_bit("ncs", idx, ncs, c.ncs);
    check_bit("nrd", idx, nrd, c.nrd);
    check_bit("nwr", idx, nwr, c.nwr);
    check_bit("busy", idx, busy, c.busy);
    check_bit("req_ready", idx, req_ready, c.req_ready);
    check_bit("wr_ready", idx, wr_ready, c.wr_ready);
    check_bit("rd_valid", idx, rd_valid, c.rd_valid);
    if (c.rd_valid) check_vec("rd_data", idx, rd_data, c.rd_data);
    if (c.oe_care) check_bit("ad_oe", idx, ad_oe, c.ad_oe);
    if (c.out_care) check_vec("ad_out", idx, ad_out, c.ad_out);
    if (c.hi_care) check_vec("a_hi", idx, {8'h00, a_hi}, {8'h00, c.a_hi});
  endtask

  int entry_no = 0;

  task automatic applyStimulus();
    cyc_t c;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      @(posedge phi);
      #1;
      req_valid = c.req_valid;
      req_addr  = c.addr;
      req_write = c.write;
      req_len   = c.len;
      cfg_ws_n  = c.wsn;
      cfg_ws_s  = c.wss;
      wr_valid  = c.wr_valid;
      wr_data   = c.wr_data;
      ad_in     = c.ad_in;
      abort     = c.abort_in;
      @(negedge phi);
      checkOutput(c, entry_no);
      entry_no++;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_bit({tag, ".ncs"}, entry_no, ncs, 1'b1);
    check_bit({tag, ".nrd"}, entry_no, nrd, 1'b1);
    check_bit({tag, ".nwr"}, entry_no, nwr, 1'b1);
    check_bit({tag, ".ad_oe"}, entry_no, ad_oe, 1'b0);
    check_vec({tag, ".ad_out"}, entry_no, ad_out, 16'h0000);
    check_vec({tag, ".a_hi"}, entry_no, {8'h00, a_hi}, 16'h0000);
    check_bit({tag, ".rd_valid"}, entry_no, rd_valid, 1'b0);
    check_bit({tag, ".wr_ready"}, entry_no, wr_ready, 1'b0);
    check_bit({tag, ".busy"}, entry_no, busy, 1'b0);
    check_bit({tag, ".req_ready"}, entry_no, req_ready, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int len, gap, abort_beat;
    logic wr;
    logic [31:0] r;

    pend = 1'b0;
    pend_data = '0;
    #1 rst = 1'b1;
    #2 check_reset_state("reset");
    #19 rst = 1'b0;

    $display("[TB] single read at 0x15BB0");
    randomize_beats();
    beat_rdv[0] = 16'hDA7A;
    add_burst(25'h15BB0, 1'b0, 0, 2, 0, 1'b0, -1);
    add_idle();
    applyStimulus();

    $display("[TB] read burst len=1 ws_n=2 ws_s=1");
    randomize_beats();
    add_burst(25'h0ABC2, 1'b0, 1, 2, 1, 1'b0, -1);
    add_idle();
    applyStimulus();

    $display("[TB] write burst with stall before second beat");
    randomize_beats();
    beat_wdata[0] = 16'h1111; beat_wdata[1] = 16'h2222; beat_wdata[2] = 16'h3333;
    beat_stall[0] = 0; beat_stall[1] = 2; beat_stall[2] = 0;
    add_burst(25'h1FFFE, 1'b1, 2, 0, 0, 1'b0, -1);
    add_idle();
    applyStimulus();

    $display("[TB] async reset during strobe");
    randomize_beats();
    add_burst(25'h0123A, 1'b0, 0, 3, 0, 1'b0, -1);
    while (plan.size() > 4) void'(plan.pop_back());
    applyStimulus();
    #2 rst = 1'b1;
    req_valid = 1'b0;
    #1 check_reset_state("mid_strobe_reset");
    @(negedge phi);
    #2 rst = 1'b0;
    randomize_beats();
    add_burst(25'h0AAAA, 1'b0, 1, 1, 0, 1'b0, -1);
    add_idle();
    applyStimulus();

    $display("[TB] abort in second recovery of len=3 read (abort enabled=%0d)", ABORT_ON);
    randomize_beats();
    add_burst(25'h1C000, 1'b0, 3, 0, 0, 1'b0, 2);
    add_idle();
    applyStimulus();

    $display("[TB] back-to-back requests with req_valid held");
    randomize_beats();
    add_burst(25'h00100, 1'b0, 1, 0, 0, 1'b1, -1);
    randomize_beats();
    add_burst(25'h00200, 1'b1, 1, 1, 0, 1'b1, -1);
    randomize_beats();
    add_burst(25'h00300, 1'b0, 0, 0, 0, 1'b1, -1);
    add_idle();
    applyStimulus();

    $display("[TB] randomized bursts");
    for (int n = 0; n < 40; n++) begin
      randomize_beats();
      r   = $urandom;
      wr  = 1'($urandom);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      abort_beat = -1;
      if (!wr && len >= 1 && $urandom_range(0, 2) == 0) abort_beat = $urandom_range(1, len);
      add_burst(r[24:0], wr, len, $urandom_range(0, 7), $urandom_range(0, 7),
                1'($urandom), abort_beat);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) add_idle();
      applyStimulus();
    end
    add_idle();
    applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
